load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequential load/store unit between the core's execute stage and `data_memory`. It takes a byte address and access type from the ALU/decoder, converts it to the word index the memory expects, and performs byte/halfword stores as a read-modify-write on the 32-bit word. It also sign- or zero-extends sub-word loads and flags misaligned, illegal or out-of-range accesses. The core stalls on `busy` and resumes on `done`.

## Interface
- `MEM_WORDS`, 65: number of words in `data_memory`. Valid word indices are 0..MEM_WORDS-1.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: start an access. Sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load. Sampled with `req`.
- `funct3` in 3: RISC-V width code. 000 B, 001 H, 010 W, 100 BU, 101 HU. Sampled with `req`.
- `addr` in 32: byte address. Sampled with `req`.
- `wdata` in 32: store data (rs2). Sampled with `req`.
- `busy` out 1: unit not in IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`. 1 = access rejected.
- `rdata` out 32: extended load result. Updated only on a successful load `done`, held otherwise.
- `mem_addr` out 32: word index, `addr_q >> 2`.
- `mem_wd` out 32: write data to memory.
- `mem_we` out 1: memory write enable.
- `mem_read` out 1: memory `MemRead`.
- `mem_rd` in 32: memory read data. Combinational, valid in the same cycle as `mem_read`.

## Operation
- Request register: on `req` in IDLE, latch `is_store`, `funct3`, `addr` and `wdata` into `*_q`.
- Byte lane `k = addr_q[1:0]`, little-endian; lane k is bits [8k+7:8k]. Halfword lane is `addr_q[1]`.
- Rejection checks, evaluated on the latched request:
  - Illegal: funct3 ∈ {011, 110, 111}, or a store with funct3[2] = 1.
  - Misaligned: H/HU with `addr[0]` = 1, or W with `addr[1:0]` ≠ 0.
  - Out of range: `addr >> 2` ≥ MEM_WORDS.
- States:
  - IDLE: `req` → CHECK; otherwise stay.
  - CHECK: rejected → DONE with `err_q` = 1. Load or sub-word store → READ. SW → WRITE.
  - READ: `mem_read` = 1; capture `mem_rd` into `word_q`. Load → DONE. Store → WRITE.
  - WRITE: `mem_we` = 1. `mem_wd` = `wdata_q` for SW, or `word_q` with only the selected lane(s) replaced by `wdata_q[7:0]` / `wdata_q[15:0]`.
  - DONE: `done` = 1, `err` = `err_q`, then → IDLE.
- Load extension, applied in READ and registered into `rdata` at the DONE transition unless `err_q`:
  - B: sign-extend the selected byte.
  - BU: zero-extend the selected byte.
  - H / HU: sign- / zero-extend the selected halfword.
  - W: whole word.
- Memory outputs (`mem_we`, `mem_read`, `mem_addr`, `mem_wd`) are decoded combinationally from state and `*_q`. Outside READ/WRITE: `mem_we` = `mem_read` = 0, `mem_addr` = `mem_wd` = 0.
- No memory access ever occurs for a rejected request.

## Timing
- Reset (asynchronous, `rst_n` low): state IDLE; `busy`, `done`, `err`, `mem_we`, `mem_read` = 0; `rdata`, `mem_addr`, `mem_wd` = 0; all `*_q` = 0.
- Reset asserted mid-WRITE: `mem_we` drops immediately, with no clock edge needed. The aborted access never produces `done`.
- Latency, counted from the cycle `req` is sampled (C0) to the `done` cycle:
  - Load: C3 (CHECK C1, READ C2, DONE C3).
  - SW: C3 (CHECK C1, WRITE C2).
  - SB/SH: C4.
  - Rejected: C2.
- `busy` is high from C1 through the `done` cycle inclusive.
- The next `req` is accepted in the cycle after `done`, so the minimum issue interval is latency + 1.
- `req` while `busy` is ignored and not queued.
- The memory write commits on the `clk` edge that ends WRITE. `rdata` changes on the edge that ends READ.

## Test plan
- Preload RAM[9] = 0x8000_80F3. LB at addr 36 → `rdata` = 0xFFFF_FFF3. LBU at 37 → 0x0000_0080. LH at 38 → 0xFFFF_8000. LHU at 36 → 0x0000_80F3. Each has `done` at C3 and `err` = 0.
- RAM[5] = 0x1122_3344. SB `wdata` = 0xAB at addr 21 → RAM[5] = 0x1122_AB44, `done` at C4. SH 0xBEEF at 22 → 0xBEEF_AB44.
- SW 33 at addr 20 → RAM[5] = 33 with exactly one `mem_we` cycle and `mem_addr` = 5. LW at 20 → `rdata` = 33.
- Reject cases: LW at 22, SH at 23, funct3 = 011, SBU (store with funct3 = 100), LW at 260 (index 65). Each → `done` with `err` = 1 at C2, `mem_we` and `mem_read` never high, `rdata` unchanged.
- Pulse `req` again during `busy` of an SB → ignored, exactly one write. Assert `rst_n` low during the WRITE cycle of an SB → `mem_we` low at once, RAM unchanged, no `done`, all outputs 0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core/memory-facing bundle of the load/store unit.
// Request side plus the word-addressed memory port; no latency of its own.
// Handshake is req-in-IDLE / done pulse; the core stalls while busy is high.
interface load_store_unit_if;
  logic        req;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic        mem_read;
  logic [31:0] mem_rd;

  modport slave (
    input  req, is_store, funct3, addr, wdata, mem_rd,
    output busy, done, err, rdata, mem_addr, mem_wd, mem_we, mem_read
  );

  modport master (
    output req, is_store, funct3, addr, wdata, mem_rd,
    input  busy, done, err, rdata, mem_addr, mem_wd, mem_we, mem_read
  );
endinterface

// File: rtl/load_store_unit.sv
// Sequential load/store unit: byte address -> word index, RMW sub-word stores, load extension.
// Latency req->done: load/SW 3 cycles, SB/SH 4 cycles, rejected access 2 cycles.
// No queueing: req is only sampled in IDLE, requests while busy are dropped.
module load_store_unit #(
  parameter int MEM_WORDS = 65
) (
  input logic               clk,
  input logic               rst_n,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_WRITE, S_DONE} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        illegal, misaligned, out_of_range, reject;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic [31:0] mem_addr_c, mem_wd_c;
  logic        mem_we_c, mem_read_c;

  // Rejection decode on the latched request; sub-word stores share the load size codes.
  always_comb begin
    illegal      = (funct3_q == 3'b011) || (funct3_q == 3'b110) || (funct3_q == 3'b111) ||
                   (is_store_q && funct3_q[2]);
    misaligned   = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((funct3_q == F3_W) && (addr_q[1:0] != 2'b00));
    out_of_range = (addr_q >> 2) >= 32'(MEM_WORDS);
    reject       = illegal || misaligned || out_of_range;
  end

  // Lane selection and extension of the word arriving from memory during READ.
  always_comb begin
    byte_v   = 8'h00;
    half_v   = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
    load_ext = bus.mem_rd;
    case (addr_q[1:0])
      2'd0:    byte_v = bus.mem_rd[7:0];
      2'd1:    byte_v = bus.mem_rd[15:8];
      2'd2:    byte_v = bus.mem_rd[23:16];
      default: byte_v = bus.mem_rd[31:24];
    endcase
    case (funct3_q)
      F3_B:    load_ext = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_ext = {24'h0, byte_v};
      F3_H:    load_ext = {{16{half_v[15]}}, half_v};
      F3_HU:   load_ext = {16'h0, half_v};
      default: load_ext = bus.mem_rd;
    endcase
  end

  // Read-modify-write merge: replace only the addressed lane(s) of the captured word.
  always_comb begin
    merged = word_q;
    if (funct3_q[1:0] == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  // Next-state, request latching and memory-port decode.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_addr_c = 32'h0;
    mem_wd_c   = 32'h0;
    mem_we_c   = 1'b0;
    mem_read_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          state_d    = S_CHECK;
          is_store_d = bus.is_store;
          funct3_d   = bus.funct3;
          addr_d     = bus.addr;
          wdata_d    = bus.wdata;
          err_d      = 1'b0;
        end
      end
      S_CHECK: begin
        if (reject) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (!is_store_q || (funct3_q != F3_W)) begin
          state_d = S_READ;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_READ: begin
        mem_read_c = 1'b1;
        mem_addr_c = addr_q >> 2;
        word_d     = bus.mem_rd;
        if (is_store_q) begin
          state_d = S_WRITE;
        end else begin
          rdata_d = load_ext;
          state_d = S_DONE;
        end
      end
      S_WRITE: begin
        mem_we_c   = 1'b1;
        mem_addr_c = addr_q >> 2;
        mem_wd_c   = (funct3_q == F3_W) ? wdata_q : merged;
        state_d    = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and request registers; async reset clears everything so mem_we drops at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      word_q     <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      word_q     <= word_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.err      = (state_q == S_DONE) && err_q;
  assign bus.rdata    = rdata_q;
  assign bus.mem_addr = mem_addr_c;
  assign bus.mem_wd   = mem_wd_c;
  assign bus.mem_we   = mem_we_c;
  assign bus.mem_read = mem_read_c;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural word RAM, scoreboard of expected completions.
// Each access is checked for err, rdata, req->done latency and memory-port activity.
// Requests are issued back-to-back in the cycle after each done.
module tb_load_store_unit;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          reads;
    int          writes;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(65)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] ram [0:64];
  logic        pre_we;
  logic [6:0]  pre_idx;
  logic [31:0] pre_val;
  int          we_cnt;
  int          rd_cnt;
  logic [31:0] last_we_addr;

  exp_t        exp_q [$];
  logic [31:0] cur_rdata;
  int          errors;
  int          checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rd = (bus.mem_read && (bus.mem_addr < 32'd65)) ? ram[bus.mem_addr[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (pre_we) ram[pre_idx] <= pre_val;
    if (bus.mem_we) begin
      if (bus.mem_addr < 32'd65) ram[bus.mem_addr[6:0]] <= bus.mem_wd;
      we_cnt       <= we_cnt + 1;
      last_we_addr <= bus.mem_addr;
    end
    if (bus.mem_read) rd_cnt <= rd_cnt + 1;
  end

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_we  = 1'b1;
    pre_idx = 7'(idx);
    pre_val = val;
    @(negedge clk);
    pre_we  = 1'b0;
  endtask

  task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                           input int exp_lat, input int exp_rds, input int exp_wes,
                           input bit poke, input string name);
    exp_t e;
    int   n;
    int   rd0;
    int   we0;
    @(negedge clk);
    rd0 = rd_cnt;
    we0 = we_cnt;
    bus.req      = 1'b1;
    bus.is_store = st;
    bus.funct3   = f3;
    bus.addr     = a;
    bus.wdata    = wd;
    e.err = exp_err; e.rdata = exp_rd; e.lat = exp_lat;
    e.reads = exp_rds; e.writes = exp_wes; e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
    bus.req = 1'b0;
    n = 1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_c1: got %0b want 1", name, bus.busy);
    end
    if (poke) begin
      bus.req      = 1'b1;
      bus.is_store = 1'b1;
      bus.funct3   = 3'b010;
      bus.addr     = 32'd0;
      bus.wdata    = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.req = 1'b0;
      n = 2;
    end
    while (bus.done !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: no done after %0d cycles, want done at C%0d", e.name, n, e.lat);
    end else begin
      if (n != e.lat) begin
        errors++;
        $display("FAIL %s latency: got C%0d want C%0d", e.name, n, e.lat);
      end
      checks++;
      if (bus.err !== e.err) begin
        errors++;
        $display("FAIL %s err: got %0b want %0b", e.name, bus.err, e.err);
      end
      checks++;
      if (bus.rdata !== e.rdata) begin
        errors++;
        $display("FAIL %s rdata: got %h want %h", e.name, bus.rdata, e.rdata);
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy_done: got %0b want 1", e.name, bus.busy);
      end
      checks++;
      if ((rd_cnt - rd0) != e.reads || (we_cnt - we0) != e.writes) begin
        errors++;
        $display("FAIL %s mem_cycles: got read=%0d we=%0d want read=%0d we=%0d",
                 e.name, rd_cnt - rd0, we_cnt - we0, e.reads, e.writes);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.req = 1'b0; bus.is_store = 1'b0; bus.funct3 = 3'b000;
    bus.addr = 32'h0; bus.wdata = 32'h0;
    pre_we = 1'b0; pre_idx = 7'd0; pre_val = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.mem_we, bus.mem_read} !== 5'b0 ||
        bus.rdata !== 32'h0 || bus.mem_addr !== 32'h0 || bus.mem_wd !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0b we=%0b rd=%0b rdata=%h addr=%h wd=%h want all 0",
               bus.busy, bus.done, bus.err, bus.mem_we, bus.mem_read, bus.rdata, bus.mem_addr, bus.mem_wd);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cur_rdata = 32'h0;
  endtask

  task automatic test_loads();
    preload(9, 32'h8000_80F3);
    do_access(1'b0, 3'b000, 32'd36, 32'h0, 1'b0, 32'hFFFF_FFF3, 3, 1, 0, 1'b0, "lb_36");
    do_access(1'b0, 3'b100, 32'd37, 32'h0, 1'b0, 32'h0000_0080, 3, 1, 0, 1'b0, "lbu_37");
    do_access(1'b0, 3'b001, 32'd38, 32'h0, 1'b0, 32'hFFFF_8000, 3, 1, 0, 1'b0, "lh_38");
    do_access(1'b0, 3'b101, 32'd36, 32'h0, 1'b0, 32'h0000_80F3, 3, 1, 0, 1'b0, "lhu_36");
    cur_rdata = 32'h0000_80F3;
  endtask

  task automatic test_stores();
    preload(5, 32'h1122_3344);
    do_access(1'b1, 3'b000, 32'd21, 32'h0000_00AB, 1'b0, cur_rdata, 4, 1, 1, 1'b0, "sb_21");
    checks++;
    if (ram[5] !== 32'h1122_AB44) begin
      errors++;
      $display("FAIL sb_21 ram5: got %h want %h", ram[5], 32'h1122_AB44);
    end
    do_access(1'b1, 3'b001, 32'd22, 32'h0000_BEEF, 1'b0, cur_rdata, 4, 1, 1, 1'b0, "sh_22");
    checks++;
    if (ram[5] !== 32'hBEEF_AB44) begin
      errors++;
      $display("FAIL sh_22 ram5: got %h want %h", ram[5], 32'hBEEF_AB44);
    end
    do_access(1'b1, 3'b010, 32'd20, 32'd33, 1'b0, cur_rdata, 3, 0, 1, 1'b0, "sw_20");
    checks++;
    if (ram[5] !== 32'd33 || last_we_addr !== 32'd5) begin
      errors++;
      $display("FAIL sw_20 ram5/addr: got %h/%0d want %h/5", ram[5], last_we_addr, 32'd33);
    end
    do_access(1'b0, 3'b010, 32'd20, 32'h0, 1'b0, 32'd33, 3, 1, 0, 1'b0, "lw_20");
    cur_rdata = 32'd33;
  endtask

  task automatic test_reject();
    do_access(1'b0, 3'b010, 32'd22,  32'h0, 1'b1, cur_rdata, 2, 0, 0, 1'b0, "rej_lw_22");
    do_access(1'b1, 3'b001, 32'd23,  32'h1, 1'b1, cur_rdata, 2, 0, 0, 1'b0, "rej_sh_23");
    do_access(1'b0, 3'b011, 32'd20,  32'h0, 1'b1, cur_rdata, 2, 0, 0, 1'b0, "rej_f3_011");
    do_access(1'b1, 3'b100, 32'd20,  32'h7, 1'b1, cur_rdata, 2, 0, 0, 1'b0, "rej_sbu");
    do_access(1'b0, 3'b010, 32'd260, 32'h0, 1'b1, cur_rdata, 2, 0, 0, 1'b0, "rej_lw_260");
    do_access(1'b0, 3'b010, 32'd256, 32'h0, 1'b0, 32'h0000_0064, 3, 1, 0, 1'b0, "lw_256_last");
    cur_rdata = 32'h0000_0064;
  endtask

  task automatic test_busy_ignore();
    int extra;
    preload(0, 32'h0000_0000);
    preload(64, 32'h0000_0064);
    do_access(1'b1, 3'b000, 32'd20, 32'h0000_0077, 1'b0, cur_rdata, 4, 1, 1, 1'b1, "sb_poked");
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || ram[0] !== 32'h0 || ram[5] !== 32'h0000_0077) begin
      errors++;
      $display("FAIL busy_ignore: got extra=%0d ram0=%h ram5=%h want 0/0/00000077", extra, ram[0], ram[5]);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] old5;
    int          seen;
    old5 = ram[5];
    @(negedge clk);
    bus.req = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b000;
    bus.addr = 32'd21; bus.wdata = 32'h0000_005A;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_write_pre: mem_we got %0b want 1", bus.mem_we);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.mem_we, bus.mem_read} !== 5'b0 ||
        bus.rdata !== 32'h0 || bus.mem_addr !== 32'h0 || bus.mem_wd !== 32'h0) begin
      errors++;
      $display("FAIL rst_write_outputs: got busy=%0b done=%0b err=%0b we=%0b rd=%0b rdata=%h addr=%h wd=%h want all 0",
               bus.busy, bus.done, bus.err, bus.mem_we, bus.mem_read, bus.rdata, bus.mem_addr, bus.mem_wd);
    end
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || ram[5] !== old5) begin
      errors++;
      $display("FAIL rst_write_after: got done=%0d ram5=%h want 0/%h", seen, ram[5], old5);
    end
    cur_rdata = 32'h0;
    do_access(1'b0, 3'b100, 32'd22, 32'h0, 1'b0, 32'h0000_0000, 3, 1, 0, 1'b0, "lbu_after_rst");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    we_cnt = 0;
    rd_cnt = 0;
    last_we_addr = 32'h0;
    test_reset();
    test_loads();
    test_stores();
    test_busy_ignore();
    test_reject();
    test_reset_mid_write();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
